// File: rtl/clk_div_pkg.sv
// Shared types and default constants for the clk_div_ctrl clock-enable scheduler.
// Used by clk_div_ctrl and div_period_cnt.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF       = 28;
    localparam int unsigned DIV_DEFAULT_DEF = 5;
    localparam int unsigned DIV_MIN_DEF     = 2;

    // PEND is RUN with an accepted divisor waiting for the next period boundary
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/div_period_cnt.sv
// Period counter for clk_div_ctrl: counts 0..div-1, flags the wrap, clears on demand.
// CLKDIV_SQUARE_OUT_EN exposes the next count value for square-wave generation.
module div_period_cnt
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             wrap
`ifdef CLKDIV_SQUARE_OUT_EN
    ,
    output logic [CNT_W-1:0] cnt_next
`endif
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // div is always >= 2, so div-1 never underflows
    assign wrap = (cnt == (div - CNT_W'(1)));

    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        if (clr || wrap) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

`ifdef CLKDIV_SQUARE_OUT_EN
    assign cnt_next = cnt_nxt;
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock-enable scheduler: one-cycle tick every cur_div cycles, with
// divisor changes deferred to a period boundary. CLKDIV_SQUARE_OUT_EN adds clock_out.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_DEF,
    parameter int unsigned DIV_MIN     = DIV_MIN_DEF
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             active,
    output logic [CNT_W-1:0] cur_div
`ifdef CLKDIV_SQUARE_OUT_EN
    ,
    output logic             clock_out
`endif
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] pend_div_next;
    logic [CNT_W-1:0] cur_div_next;
    logic             tick_next;
    logic             cfg_err_next;
    logic             xfer;
    logic             cfg_legal;
    logic             cnt_clr;
    logic             wrap;

    assign cfg_ready = (state != PEND);
    assign active    = (state != IDLE);
    assign xfer      = cfg_valid & cfg_ready;
    assign cfg_legal = (cfg_div >= CNT_W'(DIV_MIN));

    // Held at zero in IDLE (including the entry edge) and cleared on the stopping edge
    assign cnt_clr = (state == IDLE) || !run;

`ifdef CLKDIV_SQUARE_OUT_EN
    logic [CNT_W-1:0] cnt_next;

    div_period_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock_in (clock_in),
        .reset    (reset),
        .clr      (cnt_clr),
        .div      (cur_div),
        .wrap     (wrap),
        .cnt_next (cnt_next)
    );
`else
    div_period_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock_in (clock_in),
        .reset    (reset),
        .clr      (cnt_clr),
        .div      (cur_div),
        .wrap     (wrap)
    );
`endif

    always_comb begin
        state_next    = state;
        cur_div_next  = cur_div;
        pend_div_next = pend_div;
        tick_next     = 1'b0;
        cfg_err_next  = xfer && !cfg_legal;

        unique case (state)
            IDLE: begin
                if (xfer && cfg_legal) begin
                    cur_div_next = cfg_div;
                end
                if (run) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!run) begin
                    // Stop wins over a coincident wrap; a divisor accepted now takes effect directly
                    state_next = IDLE;
                    if (xfer && cfg_legal) begin
                        cur_div_next = cfg_div;
                    end
                end else begin
                    tick_next = wrap;
                    if (xfer && cfg_legal) begin
                        pend_div_next = cfg_div;
                        state_next    = PEND;
                    end
                end
            end
            PEND: begin
                if (!run) begin
                    state_next   = IDLE;
                    cur_div_next = pend_div;
                end else if (wrap) begin
                    tick_next    = 1'b1;
                    cur_div_next = pend_div;
                    state_next   = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state    <= IDLE;
            cur_div  <= CNT_W'(DIV_DEFAULT);
            pend_div <= '0;
            tick     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_next;
            cur_div  <= cur_div_next;
            pend_div <= pend_div_next;
            tick     <= tick_next;
            cfg_err  <= cfg_err_next;
        end
    end

`ifdef CLKDIV_SQUARE_OUT_EN
    // High for floor(D/2) cycles starting at each period start, so it rises with tick
    always_ff @(posedge clock_in) begin
        if (reset) begin
            clock_out <= 1'b0;
        end else begin
            clock_out <= (state_next != IDLE) && (cnt_next < (cur_div_next >> 1));
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: expected tick/cfg_err edges are queued by the stimulus
// and popped by a negedge monitor whenever the DUT pulses them.
module tb_clk_div_ctrl;

    localparam int CNT_W = 28;

    logic             clock_in = 1'b0;
    logic             reset;
    logic             run;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             tick;
    logic             active;
    logic [CNT_W-1:0] cur_div;
`ifdef CLKDIV_SQUARE_OUT_EN
    logic             clock_out;
`endif

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int tick_q[$];
    int err_q[$];
    int b;

    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) edge_n <= edge_n + 1;

    clk_div_ctrl #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (5),
        .DIV_MIN     (2)
    ) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .active    (active),
        .cur_div   (cur_div)
`ifdef CLKDIV_SQUARE_OUT_EN
        ,
        .clock_out (clock_out)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Returns #1 after posedge number e; inputs set afterwards are sampled at edge e+1
    task automatic goto(input int e);
        while (edge_n < e) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    always @(negedge clock_in) begin
        if (tick === 1'b1) begin
            if (tick_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: got tick at edge %0d expected none", edge_n);
            end else begin
                chk("tick_edge", edge_n, tick_q.pop_front());
            end
        end
        if (cfg_err === 1'b1) begin
            if (err_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cfg_err: got cfg_err at edge %0d expected none", edge_n);
            end else begin
                chk("cfg_err_edge", edge_n, err_q.pop_front());
            end
        end
`ifdef CLKDIV_SQUARE_OUT_EN
        if (active === 1'b0) chk("clock_out_idle", 32'(clock_out), 0);
        if (tick === 1'b1) chk("clock_out_at_tick", 32'(clock_out), 1);
`endif
    end

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        repeat (3) @(posedge clock_in);
        #1;
        chk("rst_active", 32'(active), 0);
        chk("rst_cur_div", 32'(cur_div), 5);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        reset = 1'b0;

        // Start with D=5, then request 8 mid-period
        run = 1'b1;
        b = edge_n + 1;
        tick_q.push_back(b + 5);
        tick_q.push_back(b + 10);
        tick_q.push_back(b + 18);
        tick_q.push_back(b + 26);
        tick_q.push_back(b + 34);
        tick_q.push_back(b + 42);
        goto(b);
        chk("run_active", 32'(active), 1);
        chk("run_cur_div", 32'(cur_div), 5);
        goto(b + 6);
        cfg_valid = 1'b1;
        cfg_div   = 28'd8;
        goto(b + 7);
        cfg_valid = 1'b0;
        chk("pend_ready", 32'(cfg_ready), 0);
        chk("pend_cur_div", 32'(cur_div), 5);
        goto(b + 9);
        chk("pend_ready_late", 32'(cfg_ready), 0);
        goto(b + 10);
        chk("applied_ready", 32'(cfg_ready), 1);
        chk("applied_cur_div", 32'(cur_div), 8);

        // Illegal divisor
        goto(b + 27);
        cfg_valid = 1'b1;
        cfg_div   = 28'd1;
        err_q.push_back(b + 28);
        goto(b + 28);
        cfg_valid = 1'b0;
        chk("bad_cur_div", 32'(cur_div), 8);
        chk("bad_ready", 32'(cfg_ready), 1);
        chk("bad_active", 32'(active), 1);

        // Stop on the wrap cycle: no tick
        goto(b + 49);
        run = 1'b0;
        goto(b + 50);
        chk("stop_active", 32'(active), 0);
        chk("stop_tick", 32'(tick), 0);

        // Restart with D=8, request 3 on a wrap cycle
        goto(b + 52);
        run = 1'b1;
        tick_q.push_back(b + 61);
        tick_q.push_back(b + 69);
        tick_q.push_back(b + 77);
        tick_q.push_back(b + 80);
        tick_q.push_back(b + 83);
        goto(b + 68);
        cfg_valid = 1'b1;
        cfg_div   = 28'd3;
        goto(b + 69);
        cfg_valid = 1'b0;
        chk("wrapreq_ready", 32'(cfg_ready), 0);
        chk("wrapreq_cur_div", 32'(cur_div), 8);
        goto(b + 77);
        chk("wrapreq_applied", 32'(cur_div), 3);
        chk("wrapreq_ready_back", 32'(cfg_ready), 1);
        goto(b + 83);
        run = 1'b0;
        goto(b + 84);
        chk("stop2_active", 32'(active), 0);

        // Legal request in IDLE, then DIV_MIN together with run
        goto(b + 85);
        cfg_valid = 1'b1;
        cfg_div   = 28'd4;
        goto(b + 86);
        chk("idle_cur_div", 32'(cur_div), 4);
        chk("idle_active", 32'(active), 0);
        cfg_div = 28'd2;
        run     = 1'b1;
        tick_q.push_back(b + 89);
        tick_q.push_back(b + 91);
        tick_q.push_back(b + 93);
        goto(b + 87);
        cfg_valid = 1'b0;
        chk("min_cur_div", 32'(cur_div), 2);
        chk("min_active", 32'(active), 1);
        goto(b + 93);
        run = 1'b0;
        goto(b + 94);
        chk("stop3_active", 32'(active), 0);

        // Reset while a divisor is pending discards it
        goto(b + 96);
        run = 1'b1;
        goto(b + 97);
        cfg_valid = 1'b1;
        cfg_div   = 28'd9;
        goto(b + 98);
        cfg_valid = 1'b0;
        chk("rstpend_ready", 32'(cfg_ready), 0);
        reset = 1'b1;
        run   = 1'b0;
        goto(b + 99);
        reset = 1'b0;
        chk("rstpend_cur_div", 32'(cur_div), 5);
        chk("rstpend_ready_back", 32'(cfg_ready), 1);
        chk("rstpend_active", 32'(active), 0);

        goto(b + 110);
        chk("tick_q_left", tick_q.size(), 0);
        chk("err_q_left", err_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
